// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - parametrised register file with busy scoreboard for the risc-16 core
//
// Register 0 reads as zero and never goes busy. Reads are combinational.
// Writes and scoreboard updates take effect on the rising clock edge.
// rst clears every register and busy bit at once, without waiting for a clock edge.
// Optional build macro GPR_BYPASS_EN forwards the writeback value to
// same-cycle reads of the destination register.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data      writeback port
//   rd_addr  [NUM_RD*ADDR_W]     packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  [NUM_RD*DATA_W]     packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy  [NUM_RD]            busy bit of each port's source register
//   issue_en, issue_addr         decode marks a register as having a pending producer
//   busy_vec [2**ADDR_W]         scoreboard, bit 0 always 0

module gpr_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // Issue is applied after the write clear, so a new producer issued in the
    // same cycle as the old producer's writeback keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_en) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_en && (wr_addr != '0)) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              fwd;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

`ifdef GPR_BYPASS_EN
        // Forwarding is suppressed during reset so reads stay zero while rst is held.
        assign fwd = !rst && wr_en && (wr_addr != '0) && (wr_addr == addr);
`else
        assign fwd = 1'b0;
`endif

        assign rd_data[k*DATA_W +: DATA_W] = fwd ? wr_data
                                           : ((addr == '0) ? '0 : regs_q[addr]);
        // A forwarded value has arrived, so the source is ready unless a new
        // producer is being issued to it in the same cycle.
        assign rd_busy[k] = fwd ? (issue_en && (issue_addr == addr)) : busy_q[addr];
    end

endmodule

// File: tb/tb_gpr_file.sv
// tb/tb_gpr_file.sv - randomized and directed self-checking bench for gpr_file
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_en;
    logic [2:0]  issue_addr;
    logic [7:0]  busy_vec;

    logic        w_wr_en;
    logic [3:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [11:0] w_rd_addr;
    logic [95:0] w_rd_data;
    logic [2:0]  w_rd_busy;
    logic        w_issue_en;
    logic [3:0]  w_issue_addr;
    logic [15:0] w_busy_vec;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] m_regs [8];
    logic        m_busy [8];

    always #5 clk = ~clk;

    gpr_file #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec)
    );

    gpr_file #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) u_wide (
        .clk(clk), .rst(rst),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
        .issue_en(w_issue_en), .issue_addr(w_issue_addr), .busy_vec(w_busy_vec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_data(input logic [2:0] a);
        if (rst || a == 3'd0) return 16'h0;
`ifdef GPR_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [2:0] a);
        if (rst || a == 3'd0) return 1'b0;
`ifdef GPR_BYPASS_EN
        if (wr_en && wr_addr == a) return issue_en && issue_addr == a;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [7:0] v;
        v = '0;
        for (int i = 1; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s rd_data[%0d]", tag, p), 32'(rd_data[p*16 +: 16]), 32'(exp_data(rd_addr[p*3 +: 3])));
            chk($sformatf("%s rd_busy[%0d]", tag, p), 32'(rd_busy[p]), 32'(exp_busy(rd_addr[p*3 +: 3])));
        end
        chk({tag, " busy_vec"}, 32'(busy_vec), 32'(exp_vec()));
    endtask

    // Inputs are already set (just after a falling edge); check, take the rising edge, return at the next falling edge.
    task automatic cycle(input string tag);
        #2;
        check_outputs(tag);
        @(posedge clk);
        if (!rst) begin
            if (wr_en && wr_addr != 3'd0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 3'd0) m_busy[issue_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr = '0;
        w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_addr = '0;
        w_issue_en = 1'b0; w_issue_addr = '0;
        model_clear();
        @(negedge clk);
        cycle("reset");
        rst = 1'b0;

        // Fill r1..r7, mark r4 busy, then pulse reset mid-cycle
        for (int i = 1; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'hA5A5;
            rd_addr = {3'(i), 3'(i - 1)};
            cycle("fill");
        end
        idle();
        issue_en = 1'b1; issue_addr = 3'd4;
        cycle("issue4");
        issue_en = 1'b1; issue_addr = 3'd6;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h7777;
        rd_addr = {3'd7, 3'd4};
        #3;
        rst = 1'b1;
        model_clear();
        #1;
        chk("async rst rd_data0", 32'(rd_data[15:0]), 32'h0);
        chk("async rst rd_data1", 32'(rd_data[31:16]), 32'h0);
        chk("async rst busy_vec", 32'(busy_vec), 32'h0);
        @(negedge clk);
        cycle("rst held");
        rst = 1'b0;
        idle();
        rd_addr = {3'd2, 3'd6};
        cycle("post rst");

        // Writes and issues to r0 are ignored
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        issue_en = 1'b1; issue_addr = 3'd0;
        rd_addr = {3'd0, 3'd0};
        cycle("r0 write");
        idle();
        chk("r0 read", 32'(rd_data[15:0]), 32'h0);
        chk("r0 busy", 32'(busy_vec[0]), 32'h0);

        // Same-cycle read of a register being written
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h0BAD;
        cycle("r3 old");
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        rd_addr = {3'd3, 3'd1};
        #1;
`ifdef GPR_BYPASS_EN
        chk("r3 same cycle", 32'(rd_data[31:16]), 32'h1234);
`else
        chk("r3 same cycle", 32'(rd_data[31:16]), 32'h0BAD);
`endif
        cycle("r3 write");
        idle();
        chk("r3 next cycle", 32'(rd_data[31:16]), 32'h1234);

        // Issue r5, write r5 three edges later
        issue_en = 1'b1; issue_addr = 3'd5;
        rd_addr = {3'd5, 3'd5};
        cycle("issue r5");
        idle();
        chk("r5 busy N+1", 32'(busy_vec[5]), 32'h1);
        cycle("r5 wait1");
        cycle("r5 wait2");
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
        cycle("write r5");
        idle();
        chk("r5 clear N+4", 32'(busy_vec[5]), 32'h0);

        // Same-edge issue and write to r2: issue wins
        issue_en = 1'b1; issue_addr = 3'd2;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0042;
        rd_addr = {3'd2, 3'd7};
        cycle("issue+write r2");
        idle();
        chk("r2 data", 32'(rd_data[31:16]), 32'h0042);
        chk("r2 still busy", 32'(busy_vec[2]), 32'h1);

        // Randomized traffic against the reference model
        for (int c = 0; c < 300; c++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 16'($urandom);
            issue_en   = ($urandom_range(0, 3) == 0);
            issue_addr = 3'($urandom_range(0, 7));
            rd_addr    = ($urandom_range(0, 7) == 0) ? {wr_addr, wr_addr} : 6'($urandom);
            cycle("random");
        end
        idle();
        cycle("drain");

        // Wide configuration: three ports read r15
        w_wr_en = 1'b1; w_wr_addr = 4'd15; w_wr_data = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        w_wr_en = 1'b0;
        w_rd_addr = {4'd15, 4'd15, 4'd15};
        #1;
        chk("wide port0", w_rd_data[31:0], 32'hDEADBEEF);
        chk("wide port1", w_rd_data[63:32], 32'hDEADBEEF);
        chk("wide port2", w_rd_data[95:64], 32'hDEADBEEF);
        chk("wide busy", 32'(w_busy_vec), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
